// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and constants for the iterative multiply-divide unit
package milano_pkg;

    // Multiply-divide operation selector, RV32M/RV64M funct3 order
    typedef enum logic [2:0] {
        MD_OP_MUL   = 3'd0,
        MD_OP_MULH  = 3'd1,
        MD_OP_MULSU = 3'd2,
        MD_OP_MULU  = 3'd3,
        MD_OP_DIV   = 3'd4,
        MD_OP_DIVU  = 3'd5,
        MD_OP_REM   = 3'd6,
        MD_OP_REMU  = 3'd7
    } md_opt_e;

    // Unit sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_e;

    // Divide operations whose result is known without iterating
    typedef enum logic [1:0] {
        MDU_SPC_NONE = 2'd0,
        MDU_SPC_DIV0 = 2'd1,
        MDU_SPC_OVF  = 2'd2
    } mdu_spc_e;

    // Quotient of a divide by zero; sliced down to XLEN by the user
    localparam logic [63:0] MDU_DIV0_QUOT = '1;

    function automatic logic md_is_mul(input md_opt_e op);
        return (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULSU, MD_OP_MULU});
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement of a W-bit value
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative multiply-divide unit, optional MULTDIV_FAST_MUL_EN single-cycle multiplier
module multdiv_iter
    import milano_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  md_opt_e         req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic [4:0]      req_rd_addr_i,
    input  logic            req_rd_we_i,
    input  logic            flush_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [4:0]      res_rd_addr_o,
    output logic            res_rd_we_o,
    output logic [XLEN-1:0] res_data_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          state_q, state_d;
    md_opt_e             op_q, op_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic                rd_we_q, rd_we_d;
    logic                sign_q, sign_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     res_data_q, res_data_d;

    logic                neg_a_en, neg_b_en, req_sign;
    logic [XLEN-1:0]     mag_a, mag_b;
    mdu_spc_e            req_spc;
    logic [XLEN-1:0]     spc_data;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step;
    logic [XLEN:0]       div_tmp;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff, div_rem_n;
    logic [2*XLEN-1:0]   div_step;
    logic [2*XLEN-1:0]   fix_in, fix_out;
    logic [XLEN-1:0]     fix_sel;

    // Request decode: operand negation, result sign and shortcut divides
    always_comb begin
        neg_a_en = 1'b0;
        neg_b_en = 1'b0;
        req_sign = 1'b0;
        req_spc  = MDU_SPC_NONE;
        spc_data = '0;
        case (req_op_i)
            MD_OP_MUL, MD_OP_MULH, MD_OP_DIV: begin
                neg_a_en = req_a_i[XLEN-1];
                neg_b_en = req_b_i[XLEN-1];
                req_sign = req_a_i[XLEN-1] ^ req_b_i[XLEN-1];
            end
            MD_OP_REM: begin
                neg_a_en = req_a_i[XLEN-1];
                neg_b_en = req_b_i[XLEN-1];
                req_sign = req_a_i[XLEN-1];
            end
            MD_OP_MULSU: begin
                neg_a_en = req_a_i[XLEN-1];
                req_sign = req_a_i[XLEN-1];
            end
            default: ;
        endcase
        if (!md_is_mul(req_op_i)) begin
            if (req_b_i == '0) begin
                req_spc  = MDU_SPC_DIV0;
                spc_data = (req_op_i inside {MD_OP_DIV, MD_OP_DIVU}) ?
                           MDU_DIV0_QUOT[XLEN-1:0] : req_a_i;
            end else if ((req_op_i inside {MD_OP_DIV, MD_OP_REM}) &&
                         (req_a_i == MOST_NEG) && (req_b_i == '1)) begin
                req_spc  = MDU_SPC_OVF;
                spc_data = (req_op_i == MD_OP_DIV) ? req_a_i : '0;
            end
        end
    end

    mdu_negate #(.W(XLEN)) u_neg_a (
        .neg_i  (neg_a_en),
        .data_i (req_a_i),
        .data_o (mag_a)
    );

    mdu_negate #(.W(XLEN)) u_neg_b (
        .neg_i  (neg_b_en),
        .data_i (req_b_i),
        .data_o (mag_b)
    );

    // One iteration step: shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_tmp   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_tmp >= {1'b0, opnd_q});
        div_diff  = div_tmp[XLEN-1:0] - opnd_q;
        div_rem_n = div_ge ? div_diff : div_tmp[XLEN-1:0];
        div_step  = {div_rem_n, acc_q[XLEN-2:0], div_ge};
    end

    // Route product, quotient or remainder through the sign fixup
    always_comb begin
        fix_in = acc_q;
        if (op_q inside {MD_OP_DIV, MD_OP_DIVU}) begin
            fix_in = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
        end else if (op_q inside {MD_OP_REM, MD_OP_REMU}) begin
            fix_in = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        end
    end

    mdu_negate #(.W(2*XLEN)) u_neg_res (
        .neg_i  (sign_q),
        .data_i (fix_in),
        .data_o (fix_out)
    );

    assign fix_sel = (op_q inside {MD_OP_MULH, MD_OP_MULSU, MD_OP_MULU}) ?
                     fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];

`ifdef MULTDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        sign_d     = sign_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    op_d      = req_op_i;
                    rd_addr_d = req_rd_addr_i;
                    rd_we_d   = req_rd_we_i;
                    sign_d    = req_sign;
                    cnt_d     = '0;
                    if (req_spc != MDU_SPC_NONE) begin
                        res_data_d = spc_data;
                        state_d    = DONE;
                    end else if (md_is_mul(req_op_i)) begin
`ifdef MULTDIV_FAST_MUL_EN
                        acc_d   = fast_prod;
                        state_d = FIXUP;
`else
                        opnd_d  = mag_a;
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                        state_d = CALC;
`endif
                    end else begin
                        opnd_d  = mag_b;
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = md_is_mul(op_q) ? mul_step : div_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                res_data_d = fix_sel;
                state_d    = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= MD_OP_MUL;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            sign_q     <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            sign_q     <= sign_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign res_valid_o   = (state_q == DONE) && !flush_i;
    assign res_data_o    = res_data_q;
    assign res_rd_addr_o = rd_addr_q;
    assign res_rd_we_o   = rd_we_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - self-checking bench for multdiv_iter against an arithmetic reference model
module tb_multdiv_iter;
    import milano_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready_o;
    md_opt_e         req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_rd_addr;
    logic            req_rd_we;
    logic            flush;
    logic            res_valid_o;
    logic            res_ready;
    logic [4:0]      res_rd_addr_o;
    logic            res_rd_we_o;
    logic [XLEN-1:0] res_data_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    multdiv_iter #(.XLEN(XLEN)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_rd_addr_i (req_rd_addr),
        .req_rd_we_i   (req_rd_we),
        .flush_i       (flush),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready),
        .res_rd_addr_o (res_rd_addr_o),
        .res_rd_we_o   (res_rd_we_o),
        .res_data_o    (res_data_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result
    function automatic logic [31:0] ref_result(input md_opt_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            MD_OP_MUL:   begin p = sa * sb; return p[31:0]; end
            MD_OP_MULH:  begin p = sa * sb; return p[63:32]; end
            MD_OP_MULSU: begin p = sa * longint'(ub); return p[63:32]; end
            MD_OP_MULU:  begin p = ua * ub; return p[63:32]; end
            MD_OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            MD_OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            MD_OP_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Cycles from the accepting edge until the result is presented
    function automatic int ref_latency(input md_opt_e op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULSU, MD_OP_MULU}) begin
`ifdef MULTDIV_FAST_MUL_EN
            return 2;
`else
            return XLEN + 2;
`endif
        end
        if (b == 0) return 1;
        if ((op inside {MD_OP_DIV, MD_OP_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            5: return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input md_opt_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic we, input int hold,
                          input logic [31:0] exp_data, input int exp_lat);
        int lat;
        int guard;
        guard = 0;
        while (!req_ready_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("ready_before_req", 64'(req_ready_o), 64'd1);
        req_valid   = 1'b1;
        req_op      = op;
        req_a       = a;
        req_b       = b;
        req_rd_addr = rd;
        req_rd_we   = we;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
        check_eq($sformatf("data op%0d a=%0h b=%0h", op, a, b), 64'(res_data_o), 64'(exp_data));
        check_eq("rd_addr", 64'(res_rd_addr_o), 64'(rd));
        check_eq("rd_we", 64'(res_rd_we_o), 64'(we));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(res_valid_o), 64'd1);
            check_eq("hold_data", 64'(res_data_o), 64'(exp_data));
            check_eq("hold_tags", 64'({res_rd_addr_o, res_rd_we_o}), 64'({rd, we}));
            check_eq("hold_ready", 64'(req_ready_o), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_eq("valid_after_hs", 64'(res_valid_o), 64'd0);
        check_eq("ready_after_hs", 64'(req_ready_o), 64'd1);
    endtask

    typedef struct {
        md_opt_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int seen;
        md_opt_e     rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;
        logic        rwe;

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = MD_OP_MUL;
        req_a       = '0;
        req_b       = '0;
        req_rd_addr = '0;
        req_rd_we   = 1'b0;
        flush       = 1'b0;
        res_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_ready", 64'(req_ready_o), 64'd1);
        check_eq("rst_valid", 64'(res_valid_o), 64'd0);
        check_eq("rst_data", 64'(res_data_o), 64'd0);
        check_eq("rst_tags", 64'({res_rd_addr_o, res_rd_we_o}), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);

        vecs.push_back('{MD_OP_MUL,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
        vecs.push_back('{MD_OP_MULH,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
        vecs.push_back('{MD_OP_MULSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{MD_OP_MULU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{MD_OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{MD_OP_REM,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{MD_OP_DIVU,  32'd5,          32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{MD_OP_REMU,  32'd5,          32'd0,         32'd5});
        vecs.push_back('{MD_OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{MD_OP_REM,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{MD_OP_REMU,  32'hFFFF_FFF9,  32'd2,         32'd1});
        vecs.push_back('{MD_OP_MUL,   32'd3,          32'd4,         32'd12});

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), i[0], (i == 0) ? 5 : 0,
                   vecs[i].exp, ref_latency(vecs[i].op, vecs[i].a, vecs[i].b));
        end

        // flush while idle must not start an operation
        req_valid = 1'b1;
        req_op    = MD_OP_DIVU;
        req_a     = 32'd100;
        req_b     = 32'd7;
        flush     = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check_eq("idle_flush_busy", 64'(busy_o), 64'd0);

        // flush in the middle of a divide
        req_valid   = 1'b1;
        req_op      = MD_OP_DIVU;
        req_a       = 32'd1000;
        req_b       = 32'd3;
        req_rd_addr = 5'd9;
        req_rd_we   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("calc_busy", 64'(busy_o), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_ready", 64'(req_ready_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid_o) seen++;
            @(posedge clk); #1;
        end
        check_eq("flush_no_valid", 64'(seen), 64'd0);
        run_op(MD_OP_DIVU, 32'd1000, 32'd3, 5'd17, 1'b0, 0, 32'd333,
               ref_latency(MD_OP_DIVU, 32'd1000, 32'd3));

        // randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = md_opt_e'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            rrd = 5'($urandom_range(0, 31));
            rwe = 1'($urandom_range(0, 1));
            run_op(rop, ra, rb, rrd, rwe, $urandom_range(0, 2),
                   ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
        end

        // reset in the middle of an operation returns outputs to reset values
        req_valid   = 1'b1;
        req_op      = MD_OP_MULU;
        req_a       = 32'd123;
        req_b       = 32'd45;
        req_rd_addr = 5'd21;
        req_rd_we   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_ready", 64'(req_ready_o), 64'd1);
        check_eq("midrst_valid", 64'(res_valid_o), 64'd0);
        check_eq("midrst_busy", 64'(busy_o), 64'd0);
        check_eq("midrst_data", 64'(res_data_o), 64'd0);
        check_eq("midrst_tags", 64'({res_rd_addr_o, res_rd_we_o}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
